ptw_multilevel: RTL

- Parametrised successor to the fixed two-level page table walker.
- Walks a LEVELS-deep radix page table in memory for one translation at a time, using the same valid/ready request and response handshakes toward the TLB and the memory port.
- Adds a per-request root base, superpage (early leaf) termination, and explicit fault and level reporting.
- Sits between the TLB miss path and the memory module.

---
 rtl/ptw_multilevel.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ptw_multilevel.sv
// Radix page table walker: walks a LEVELS-deep table from a per-request root,
// stopping early on superpage leaves and reporting faults and the final level.
module ptw_multilevel #(
   parameter int ADDR_W   = 32,
   parameter int PTE_W    = 32,
   parameter int LEVELS   = 2,
   parameter int VPN_W    = 10,
   parameter int OFFSET_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ptw_req_valid_i,
   output logic              ptw_req_ready_o,
   input  logic [ADDR_W-1:0] ptw_vaddr_i,
   input  logic [ADDR_W-1:0] ptw_root_i,
   output logic              ptw_resp_valid_o,
   input  logic              ptw_resp_ready_i,
   output logic [PTE_W-1:0]  ptw_pte_o,
   output logic              ptw_fault_o,
   output logic [1:0]        ptw_level_o,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_resp_valid_i,
   output logic              mem_resp_ready_o,
   input  logic [PTE_W-1:0]  mem_data_i
);

   typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] vaddr_q, vaddr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [1:0]        level_q, level_d;
   logic [PTE_W-1:0]  pte_q, pte_d;
   logic              fault_q, fault_d;
   logic [1:0]        end_level_q, end_level_d;

   logic [VPN_W-1:0]  vpn;
   logic [ADDR_W-1:0] vpn_offset;
   logic [ADDR_W-1:0] pte_addr;
   logic [ADDR_W-1:0] ptr_base;
   logic              pte_v, pte_r, pte_w, pte_x;
   logic              unused_bits;

   // Pick the VPN slice for the level currently being walked.
   always_comb begin
      vpn = '0;
      for (int l = 0; l < LEVELS; l++) begin
         if (level_q == 2'(l)) begin
            vpn = vaddr_q[OFFSET_W + l*VPN_W +: VPN_W];
         end
      end
   end

   always_comb begin
      vpn_offset = '0;
      vpn_offset[VPN_W+1:2] = vpn;
   end

   assign pte_addr = base_q + vpn_offset;
   assign ptr_base = ADDR_W'({mem_data_i[PTE_W-1:10], 10'b0});
   assign pte_v    = mem_data_i[0];
   assign pte_r    = mem_data_i[1];
   assign pte_w    = mem_data_i[2];
   assign pte_x    = mem_data_i[3];

   assign unused_bits = ^{vaddr_q, ptw_vaddr_i, mem_data_i};

   assign mem_addr_o  = (state_q == MREQ) ? pte_addr : '0;
   assign ptw_pte_o   = pte_q;
   assign ptw_fault_o = fault_q;
   assign ptw_level_o = end_level_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         vaddr_q     <= '0;
         base_q      <= '0;
         level_q     <= '0;
         pte_q       <= '0;
         fault_q     <= 1'b0;
         end_level_q <= '0;
      end else begin
         state_q     <= state_d;
         vaddr_q     <= vaddr_d;
         base_q      <= base_d;
         level_q     <= level_d;
         pte_q       <= pte_d;
         fault_q     <= fault_d;
         end_level_q <= end_level_d;
      end
   end

   // Invalid entries, write-without-read and pointers past the last level all fault.
   always_comb begin
      state_d          = state_q;
      vaddr_d          = vaddr_q;
      base_d           = base_q;
      level_d          = level_q;
      pte_d            = pte_q;
      fault_d          = fault_q;
      end_level_d      = end_level_q;
      ptw_req_ready_o  = 1'b0;
      mem_req_valid_o  = 1'b0;
      mem_resp_ready_o = 1'b0;
      ptw_resp_valid_o = 1'b0;

      case (state_q)
         IDLE: begin
            ptw_req_ready_o = 1'b1;
            if (ptw_req_valid_i) begin
               vaddr_d = ptw_vaddr_i;
               base_d  = ptw_root_i;
               level_d = 2'(LEVELS - 1);
               state_d = MREQ;
            end
         end
         MREQ: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) begin
               state_d = MWAIT;
            end
         end
         MWAIT: begin
            mem_resp_ready_o = 1'b1;
            if (mem_resp_valid_i) begin
               if (!pte_v || (pte_w && !pte_r)) begin
                  pte_d       = '0;
                  fault_d     = 1'b1;
                  end_level_d = level_q;
                  state_d     = RESP;
               end else if (!pte_r && !pte_w && !pte_x) begin
                  if (level_q == 2'd0) begin
                     pte_d       = '0;
                     fault_d     = 1'b1;
                     end_level_d = level_q;
                     state_d     = RESP;
                  end else begin
                     base_d  = ptr_base;
                     level_d = level_q - 2'd1;
                     state_d = MREQ;
                  end
               end else begin
                  pte_d       = mem_data_i;
                  fault_d     = 1'b0;
                  end_level_d = level_q;
                  state_d     = RESP;
               end
            end
         end
         RESP: begin
            ptw_resp_valid_o = 1'b1;
            if (ptw_resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
